ov5640_cfg_seq: RTL and testbench

OV5640_CFG_SEQ -- requirements
Module: ov5640_cfg_seq

---
 rtl/ov5640_cfg_seq_pkg.sv | 51 +++++
 rtl/ov5640_cfg_seq.sv | 197 +++++++++++++++++++
 tb/tb_ov5640_cfg_seq.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ov5640_cfg_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ov5640_cfg_seq_pkg
// Brief   : Shared camera parameters: SCCB command encodings, table entry layout
// Revision: 1.0 - initial release
// ============================================================================
package ov5640_cfg_seq_pkg;

    localparam logic [3:0]  CMD_START    = 4'b0001;
    localparam logic [3:0]  CMD_WRITE    = 4'b0010;
    localparam logic [3:0]  CMD_READ     = 4'b0100;
    localparam logic [3:0]  CMD_STOP     = 4'b1000;

    localparam logic [15:0] DLY_MARK     = 16'hFFFF;
    localparam logic [15:0] SOFT_RST_REG = 16'h3008;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  val;
    } cfg_entry_t;

    typedef enum logic [3:0] {
        PWR_WAIT = 4'd0,
        FETCH    = 4'd1,
        PUSH     = 4'd2,
        REQ      = 4'd3,
        WAIT_HI  = 4'd4,
        WAIT_LO  = 4'd5,
        CHECK    = 4'd6,
        DELAY    = 4'd7,
        DONE     = 4'd8,
        ERR      = 4'd9
    } cfg_state_t;

    // Returns {cmd, byte} for push slot idx of a write (rd=0) or readback (rd=1) transaction.
    function automatic logic [11:0] push_item(input logic rd, input logic [2:0] idx,
                                              input cfg_entry_t e, input logic [7:0] dev);
        logic [11:0] item;
        case (idx)
            3'd0:    item = {CMD_START | CMD_WRITE, dev};
            3'd1:    item = {CMD_WRITE, e.addr[15:8]};
            3'd2:    item = {CMD_WRITE, e.addr[7:0]};
            3'd3:    item = rd ? {CMD_START | CMD_WRITE, dev | 8'h01}
                               : {CMD_STOP | CMD_WRITE, e.val};
            default: item = {CMD_STOP | CMD_READ, 8'h00};
        endcase
        return item;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ov5640_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module  : ov5640_cfg_seq
// Brief   : Walks the OV5640 register table and drives the SCCB engine; optional
//           readback verify enabled by `define OV5640_CFG_READBACK_EN
// Revision: 1.0 - initial release
// ============================================================================
module ov5640_cfg_seq
    import ov5640_cfg_seq_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR = 8'h78,
    parameter int         REG_NUM  = 252,
    parameter int         PWR_DLY  = 1_000_000,
    parameter int         SW_DLY   = 250_000,
    parameter int         TMO      = 2**20
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [7:0]  tbl_addr,
    input  logic [23:0] tbl_data,
    output logic        req,
    output logic [3:0]  cmd,
    output logic        cmd_vld,
    output logic [7:0]  wr_din,
    output logic        wr_din_vld,
    input  logic        slave_busy,
    input  logic        fail,
    input  logic [7:0]  rd_dout,
    input  logic        rd_dout_vld,
    output logic        cfg_done,
    output logic        cfg_err
);

    localparam logic [31:0] PWR_LAST = 32'(PWR_DLY - 1);
    localparam logic [31:0] SW_LAST  = 32'(SW_DLY - 1);
    localparam logic [31:0] TMO_LAST = 32'(TMO - 1);
    localparam logic [7:0]  LAST_IDX = 8'(REG_NUM - 1);

    cfg_state_t  state;
    cfg_entry_t  entry;
    logic [31:0] dly_cnt;
    logic [31:0] tmo_cnt;
    logic [2:0]  push_idx;
    logic [2:0]  push_last;
    logic        rd_phase;

`ifdef OV5640_CFG_READBACK_EN
    logic [7:0]  rd_q;
    logic        rd_got;
`else
    logic        unused_rd;
    assign rd_phase  = 1'b0;
    assign unused_rd = ^{rd_dout, rd_dout_vld};
`endif

    assign push_last = rd_phase ? 3'd4 : 3'd3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PWR_WAIT;
            entry      <= '0;
            dly_cnt    <= '0;
            tmo_cnt    <= '0;
            push_idx   <= '0;
            tbl_addr   <= '0;
            req        <= 1'b0;
            cmd        <= '0;
            cmd_vld    <= 1'b0;
            wr_din     <= '0;
            wr_din_vld <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
`ifdef OV5640_CFG_READBACK_EN
            rd_phase   <= 1'b0;
            rd_q       <= '0;
            rd_got     <= 1'b0;
`endif
        end else begin
`ifdef OV5640_CFG_READBACK_EN
            if (rd_dout_vld) begin
                rd_q   <= rd_dout;
                rd_got <= 1'b1;
            end
`endif
            case (state)
                PWR_WAIT: begin
                    if (dly_cnt == PWR_LAST) begin
                        dly_cnt <= '0;
                        state   <= FETCH;
                    end else begin
                        dly_cnt <= dly_cnt + 32'd1;
                    end
                end
                FETCH: begin
                    // Holding here keeps any push from overlapping a busy engine.
                    if (!slave_busy) begin
                        entry <= tbl_data;
                        if (tbl_data[23:8] == DLY_MARK) begin
                            dly_cnt <= '0;
                            state   <= DELAY;
                        end else begin
                            {cmd, wr_din} <= push_item(1'b0, 3'd0, tbl_data, DEV_ADDR);
                            cmd_vld       <= 1'b1;
                            wr_din_vld    <= 1'b1;
                            push_idx      <= 3'd1;
                            state         <= PUSH;
                        end
                    end
                end
                PUSH: begin
                    if (push_idx > push_last) begin
                        cmd_vld    <= 1'b0;
                        wr_din_vld <= 1'b0;
                        req        <= 1'b1;
                        tmo_cnt    <= '0;
                        state      <= REQ;
                    end else begin
                        {cmd, wr_din} <= push_item(rd_phase, push_idx, entry, DEV_ADDR);
                        push_idx      <= push_idx + 3'd1;
                    end
                end
                REQ, WAIT_HI, WAIT_LO: begin
                    if (tmo_cnt == TMO_LAST) begin
                        req     <= 1'b0;
                        cfg_err <= 1'b1;
                        state   <= ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                        if (state == REQ) begin
                            if (slave_busy) begin
                                req   <= 1'b0;
                                state <= WAIT_HI;
                            end
                        end else if (state == WAIT_HI) begin
                            state <= WAIT_LO;
                        end else if (!slave_busy) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (fail) begin
                        cfg_err <= 1'b1;
                        state   <= ERR;
`ifdef OV5640_CFG_READBACK_EN
                    end else if (rd_phase && (!rd_got || rd_q != entry.val)) begin
                        cfg_err <= 1'b1;
                        state   <= ERR;
                    end else if (!rd_phase && entry.addr != SOFT_RST_REG) begin
                        // Soft reset self-clears, so only other registers are read back.
                        rd_phase      <= 1'b1;
                        rd_got        <= 1'b0;
                        {cmd, wr_din} <= push_item(1'b1, 3'd0, entry, DEV_ADDR);
                        cmd_vld       <= 1'b1;
                        wr_din_vld    <= 1'b1;
                        push_idx      <= 3'd1;
                        state         <= PUSH;
`endif
                    end else begin
`ifdef OV5640_CFG_READBACK_EN
                        rd_phase <= 1'b0;
`endif
                        if (tbl_addr == LAST_IDX) begin
                            cfg_done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            tbl_addr <= tbl_addr + 8'd1;
                            state    <= FETCH;
                        end
                    end
                end
                DELAY: begin
                    if (dly_cnt == SW_LAST) begin
                        dly_cnt <= '0;
                        if (tbl_addr == LAST_IDX) begin
                            cfg_done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            tbl_addr <= tbl_addr + 8'd1;
                            state    <= FETCH;
                        end
                    end else begin
                        dly_cnt <= dly_cnt + 32'd1;
                    end
                end
                DONE: state <= DONE;
                ERR:  state <= ERR;
                default: begin
                    cfg_err <= 1'b1;
                    state   <= ERR;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ov5640_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_ov5640_cfg_seq
// Brief   : Directed bench for ov5640_cfg_seq with a small SCCB engine model
// Revision: 1.0 - initial release
// ============================================================================
module tb_ov5640_cfg_seq;

    localparam int TMO_T = 64;

`ifdef OV5640_CFG_READBACK_EN
    localparam int NACK_ENTRY1 = 2;
    localparam int V1_N        = 13;
    localparam int V3_N        = 9;
    localparam int V1_READS    = 1;
    logic [11:0] exp_v1 [0:12] = '{12'h378, 12'h231, 12'h203, 12'hA11,
                                   12'h378, 12'h231, 12'h203, 12'h379, 12'hC00,
                                   12'h378, 12'h230, 12'h208, 12'hA82};
`else
    localparam int NACK_ENTRY1 = 1;
    localparam int V1_N        = 8;
    localparam int V3_N        = 4;
    localparam int V1_READS    = 0;
    logic [11:0] exp_v1 [0:7]  = '{12'h378, 12'h231, 12'h203, 12'hA11,
                                   12'h378, 12'h230, 12'h208, 12'hA82};
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  tbl_addr;
    logic [23:0] tbl_data;
    logic        req;
    logic [3:0]  cmd;
    logic        cmd_vld;
    logic [7:0]  wr_din;
    logic        wr_din_vld;
    logic        slave_busy;
    logic        fail;
    logic [7:0]  rd_dout;
    logic        rd_dout_vld;
    logic        cfg_done;
    logic        cfg_err;

    logic [23:0] rom [0:1];
    assign tbl_data = rom[tbl_addr[0]];

    ov5640_cfg_seq #(
        .DEV_ADDR (8'h78),
        .REG_NUM  (2),
        .PWR_DLY  (10),
        .SW_DLY   (100),
        .TMO      (TMO_T)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tbl_addr    (tbl_addr),
        .tbl_data    (tbl_data),
        .req         (req),
        .cmd         (cmd),
        .cmd_vld     (cmd_vld),
        .wr_din      (wr_din),
        .wr_din_vld  (wr_din_vld),
        .slave_busy  (slave_busy),
        .fail        (fail),
        .rd_dout     (rd_dout),
        .rd_dout_vld (rd_dout_vld),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Engine model configuration and observation
    int          busy_len = 3;
    bit          stuck    = 0;
    int          nack_txn = -1;
    bit          rd_bad   = 0;
    int          cyc, first_push, req_cyc, err_cyc, txn, busy_cnt, busy_push;
    bit          cur_rd;
    logic [7:0]  last_val;
    logic [11:0] push_q [$];

    initial begin
        slave_busy  = 1'b0;
        fail        = 1'b0;
        rd_dout     = 8'h00;
        rd_dout_vld = 1'b0;
        last_val    = 8'h00;
        forever begin
            @(negedge clk);
            rd_dout_vld = 1'b0;
            if (!rst_n) begin
                slave_busy = 1'b0;
                fail       = 1'b0;
                busy_cnt   = 0;
                txn        = 0;
                cyc        = 0;
                first_push = -1;
                req_cyc    = -1;
                err_cyc    = -1;
                busy_push  = 0;
                cur_rd     = 0;
                push_q.delete();
            end else begin
                cyc++;
                if (cmd_vld) begin
                    if (first_push < 0) first_push = cyc;
                    if (slave_busy) busy_push++;
                    push_q.push_back({cmd, wr_din});
                    if (cmd[2]) cur_rd = 1;
                    if (cmd == 4'b1010) last_val = wr_din;
                end
                if (cfg_err && err_cyc < 0) err_cyc = cyc;
                if (busy_cnt > 0) begin
                    if (!stuck) begin
                        busy_cnt--;
                        if (busy_cnt == 0) begin
                            slave_busy = 1'b0;
                            if (txn == nack_txn) fail = 1'b1;
                            if (cur_rd) begin
                                rd_dout     = rd_bad ? 8'h10 : last_val;
                                rd_dout_vld = 1'b1;
                            end
                            cur_rd = 0;
                            txn++;
                        end
                    end
                end else if (req) begin
                    slave_busy = 1'b1;
                    busy_cnt   = busy_len;
                    if (req_cyc < 0) req_cyc = cyc;
                end
            end
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_end(input int limit);
        int n = 0;
        while (!(cfg_done || cfg_err) && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    function automatic int count_reads();
        int r = 0;
        foreach (push_q[i]) if (push_q[i][10]) r++;
        return r;
    endfunction

    initial begin
        int np;
        rst_n  = 1'b0;
        rom[0] = 24'h3103_11;
        rom[1] = 24'h3008_82;
        #1;
        check_eq("reset_outputs",
                 {7'd0, req, cmd, cmd_vld, wr_din, wr_din_vld, tbl_addr, cfg_done, cfg_err}, 32'd0);

        // V1: two write entries acknowledged
        do_reset();
        wait_end(2000);
        check_eq("v1_first_push_cycle", first_push, 11);
        check_eq("v1_push_count", push_q.size(), V1_N);
        for (int i = 0; i < V1_N; i++)
            check_eq($sformatf("v1_push%0d", i), (i < push_q.size()) ? push_q[i] : 12'hFFF, exp_v1[i]);
        check_eq("v1_done", cfg_done, 1);
        check_eq("v1_err", cfg_err, 0);
        check_eq("v1_read_cmds", count_reads(), V1_READS);
        check_eq("v1_push_while_busy", busy_push, 0);

        // V2: second entry NACKed
        nack_txn = NACK_ENTRY1;
        do_reset();
        wait_end(2000);
        check_eq("v2_err", cfg_err, 1);
        check_eq("v2_done", cfg_done, 0);
        check_eq("v2_tbl_addr", tbl_addr, 1);
        np = push_q.size();
        repeat (30) @(negedge clk);
        check_eq("v2_no_more_push", push_q.size(), np);
        nack_txn = -1;

        // V3: delay marker, then a normal entry
        rom[0] = 24'hFFFF_00;
        rom[1] = 24'h3103_11;
        do_reset();
        wait_end(2000);
        check_eq("v3_first_push_cycle", first_push, 112);
        check_eq("v3_push_count", push_q.size(), V3_N);
        check_eq("v3_push0", (push_q.size() > 0) ? push_q[0] : 12'hFFF, 12'h378);
        check_eq("v3_push1", (push_q.size() > 1) ? push_q[1] : 12'hFFF, 12'h231);
        check_eq("v3_done", cfg_done, 1);
        check_eq("v3_tbl_addr", tbl_addr, 1);

        // V4: engine never releases busy
        rom[0] = 24'h3103_11;
        rom[1] = 24'h3008_82;
        stuck  = 1;
        do_reset();
        wait_end(2000);
        check_eq("v4_err", cfg_err, 1);
        check_eq("v4_done", cfg_done, 0);
        check_eq("v4_tmo_cycles", 32'(err_cyc - req_cyc), TMO_T);
        stuck = 0;

`ifdef OV5640_CFG_READBACK_EN
        // V5: readback returns a wrong value
        rd_bad = 1;
        do_reset();
        wait_end(2000);
        check_eq("v5_err", cfg_err, 1);
        check_eq("v5_tbl_addr", tbl_addr, 0);
        check_eq("v5_push_count", push_q.size(), 9);
        check_eq("v5_read_addr", (push_q.size() > 7) ? push_q[7] : 12'hFFF, 12'h379);
        check_eq("v5_read_dummy", (push_q.size() > 8) ? push_q[8] : 12'hFFF, 12'hC00);
        rd_bad = 0;
`endif

        // V6: reset while waiting for busy to fall on entry 1
        busy_len = 20;
        do_reset();
        for (int i = 0; i < 500 && !(txn == NACK_ENTRY1 && slave_busy); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check_eq("v6_busy_before_reset", slave_busy, 1);
        check_eq("v6_tbl_addr_before_reset", tbl_addr, 1);
        rst_n = 1'b0;
        #1;
        check_eq("v6_outputs_in_reset",
                 {7'd0, req, cmd, cmd_vld, wr_din, wr_din_vld, tbl_addr, cfg_done, cfg_err}, 32'd0);
        busy_len = 3;
        do_reset();
        wait_end(2000);
        check_eq("v6_first_push_cycle", first_push, 11);
        check_eq("v6_push0", (push_q.size() > 0) ? push_q[0] : 12'hFFF, 12'h378);
        check_eq("v6_push1", (push_q.size() > 1) ? push_q[1] : 12'hFFF, 12'h231);
        check_eq("v6_done", cfg_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
